// File: rtl/fetch_aligner_if.sv
// Fetch, expander and decode-side signals of the fetch aligner.
// master = aligner side, slave = memory/expander/decode side.
interface fetch_aligner_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_enable;
    logic [15:0] dec_half;
    logic [31:0] dec_word;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_compressed;
    logic        instr_illegal;

    modport master (
        output fetch_req, fetch_addr, dec_enable, dec_half,
        output instr_valid, instr, instr_pc,
        output instr_compressed, instr_illegal,
        input  fetch_valid, fetch_data, redirect, redirect_pc,
        input  dec_word, instr_ready
    );

    modport slave (
        input  fetch_req, fetch_addr, dec_enable, dec_half,
        input  instr_valid, instr, instr_pc,
        input  instr_compressed, instr_illegal,
        output fetch_valid, fetch_data, redirect, redirect_pc,
        output dec_word, instr_ready
    );
endinterface

// File: rtl/fetch_aligner.sv
// Splits fetch words into 16/32-bit parcels, stitches spanning
// instructions and hands one expanded instruction at a time to decode.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          ENABLE_C = 1'b1
) (
    input logic clk,
    input logic reset,
    fetch_aligner_if.master bus
);
    typedef enum logic [1:0] {
        FETCH, ISSUE, FETCH_HI, ISSUE_SPAN
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] w, w_n;
    logic [15:0] l, l_n;
    logic [15:0] h;
    logic        comp;

    logic        req_o;
    logic [31:0] addr_o;
    logic        den_o;
    logic [15:0] dhalf_o;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] ipc_o;
    logic        comp_o;
    logic        ill_o;

    // State, PC, fetched word and spanning low half
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            w     <= 32'h0;
            l     <= 16'h0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            w     <= w_n;
            l     <= l_n;
        end
    end

    // Next-state, PC advance and output decode
    always_comb begin
        state_n = state;
        pc_n    = pc;
        w_n     = w;
        l_n     = l;
        req_o   = 1'b0;
        addr_o  = 32'h0;
        den_o   = 1'b0;
        dhalf_o = 16'h0;
        valid_o = 1'b0;
        instr_o = 32'h0;
        ipc_o   = 32'h0;
        comp_o  = 1'b0;
        ill_o   = 1'b0;
        h       = pc[1] ? w[31:16] : w[15:0];
        comp    = (h[1:0] != 2'b11);

        unique case (state)
            FETCH, FETCH_HI: begin
                req_o  = 1'b1;
                addr_o = {pc[31:2] + {29'd0, state == FETCH_HI},
                          2'b00};
                if (bus.fetch_valid) begin
                    w_n     = bus.fetch_data;
                    state_n = (state == FETCH) ? ISSUE : ISSUE_SPAN;
                end
            end
            ISSUE: begin
                ipc_o = pc;
                if (comp) begin
                    valid_o = 1'b1;
                    comp_o  = 1'b1;
                    if (ENABLE_C) begin
                        den_o   = 1'b1;
                        dhalf_o = h;
                        instr_o = bus.dec_word;
                        ill_o   = (bus.dec_word == 32'h0);
                    end else begin
                        ill_o   = 1'b1;
                    end
                    if (bus.instr_ready) begin
                        pc_n = pc + 32'd2;
                        if (pc[1])
                            state_n = FETCH;
                    end
                end else if (!pc[1]) begin
                    valid_o = 1'b1;
                    instr_o = w;
                    if (bus.instr_ready) begin
                        pc_n    = pc + 32'd4;
                        state_n = FETCH;
                    end
                end else begin
                    l_n     = w[31:16];
                    state_n = FETCH_HI;
                end
            end
            ISSUE_SPAN: begin
                ipc_o   = pc;
                valid_o = 1'b1;
                instr_o = {w[15:0], l};
                if (bus.instr_ready) begin
                    pc_n    = pc + 32'd4;
                    state_n = ISSUE;
                end
            end
        endcase

        if (bus.redirect) begin
            valid_o = 1'b0;
            w_n     = w;
            l_n     = 16'h0;
            pc_n    = bus.redirect_pc;
            state_n = FETCH;
        end

        if (reset) begin
            req_o   = 1'b0;
            addr_o  = 32'h0;
            den_o   = 1'b0;
            dhalf_o = 16'h0;
            valid_o = 1'b0;
            instr_o = 32'h0;
            ipc_o   = 32'h0;
            comp_o  = 1'b0;
            ill_o   = 1'b0;
        end
    end

    assign bus.fetch_req        = req_o;
    assign bus.fetch_addr       = addr_o;
    assign bus.dec_enable       = den_o;
    assign bus.dec_half         = dhalf_o;
    assign bus.instr_valid      = valid_o;
    assign bus.instr            = instr_o;
    assign bus.instr_pc         = ipc_o;
    assign bus.instr_compressed = comp_o;
    assign bus.instr_illegal    = ill_o;
endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner: word split, span stitching,
// stall, redirect, wrap and illegal parcels.
module tb_fetch_aligner;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    fetch_aligner_if f();
    fetch_aligner_if f2();

    fetch_aligner #(.RESET_PC(32'h0), .ENABLE_C(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(f.master)
    );
    fetch_aligner #(.RESET_PC(32'h0), .ENABLE_C(1'b0)) dut2 (
        .clk(clk), .reset(reset), .bus(f2.master)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:127];
    logic        mem_ok = 1'b1;
    logic        rdy = 1'b1;
    logic        rdy2 = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    int          fcount = 0;
    int          acc = 0;
    logic [31:0] last_addr = 32'h0;

    function automatic logic [31:0] xlate(input logic [15:0] hw);
        case (hw)
            16'h4505: xlate = 32'h0010_0513;
            16'h0505: xlate = 32'h0015_0513;
            16'h4501: xlate = 32'h0000_0513;
            default:  xlate = 32'h0;
        endcase
    endfunction

    assign f.fetch_valid  = f.fetch_req & mem_ok;
    assign f.fetch_data   = mem[f.fetch_addr[8:2]];
    assign f.redirect     = redir;
    assign f.redirect_pc  = redir_pc;
    assign f.dec_word     = xlate(f.dec_half);
    assign f.instr_ready  = rdy;

    assign f2.fetch_valid = f2.fetch_req;
    assign f2.fetch_data  = 32'h4505_4505;
    assign f2.redirect    = 1'b0;
    assign f2.redirect_pc = 32'h0;
    assign f2.dec_word    = xlate(f2.dec_half);
    assign f2.instr_ready = rdy2;

    always @(posedge clk) begin
        if (!reset && f.fetch_req && f.fetch_valid && !f.redirect) begin
            fcount    <= fcount + 1;
            last_addr <= f.fetch_addr;
        end
        if (!reset && f.instr_valid && f.instr_ready)
            acc <= acc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redir = 1'b0;
        step();
        check("rst_req", 32'(f.fetch_req), 32'h0);
        check("rst_valid", 32'(f.instr_valid), 32'h0);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_req", 32'(f.fetch_req), 32'h1);
        check("post_rst_addr", f.fetch_addr, 32'h0);
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] i,
                                input logic [31:0] pc, input logic c,
                                input logic il);
        int n = 0;
        while (!f.instr_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(f.instr_valid), 32'h1);
        check({tag, "_instr"}, f.instr, i);
        check({tag, "_pc"}, f.instr_pc, pc);
        check({tag, "_comp"}, 32'(f.instr_compressed), 32'(c));
        check({tag, "_ill"}, 32'(f.instr_illegal), 32'(il));
        step();
    endtask

    initial begin
        int f0;
        int a0;
        int n;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;

        // 32-bit aligned instruction
        mem[0] = 32'h00A0_0093;
        do_reset();
        expect_instr("a", 32'h00A0_0093, 32'h0, 1'b0, 1'b0);
        check("a_next_addr", f.fetch_addr, 32'h4);
        check("a_next_req", 32'(f.fetch_req), 32'h1);

        // two compressed parcels in one word
        mem[0] = {16'h4505, 16'h0505};
        do_reset();
        f0 = fcount;
        expect_instr("b0", 32'h0015_0513, 32'h0, 1'b1, 1'b0);
        expect_instr("b1", 32'h0010_0513, 32'h2, 1'b1, 1'b0);
        check("b_fetches", 32'(fcount - f0), 32'h1);
        check("b_next_addr", f.fetch_addr, 32'h4);

        // compressed, spanning 32-bit, then illegal parcel
        mem[0] = {16'h0093, 16'h4501};
        mem[1] = {16'h0000, 16'h00A0};
        do_reset();
        f0 = fcount;
        expect_instr("c0", 32'h0000_0513, 32'h0, 1'b1, 1'b0);
        expect_instr("c1", 32'h00A0_0093, 32'h2, 1'b0, 1'b0);
        expect_instr("c2", 32'h0, 32'h6, 1'b1, 1'b1);
        check("c_fetches", 32'(fcount - f0), 32'h2);
        check("c_last_addr", last_addr, 32'h4);
        check("c_next_addr", f.fetch_addr, 32'h8);

        // decode stall
        mem[0] = 32'h00A0_0093;
        rdy = 1'b0;
        do_reset();
        n = 0;
        while (!f.instr_valid && n < 20) begin
            step();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("d_valid", 32'(f.instr_valid), 32'h1);
            check("d_instr", f.instr, 32'h00A0_0093);
            check("d_pc", f.instr_pc, 32'h0);
            check("d_req", 32'(f.fetch_req), 32'h0);
            step();
        end
        a0 = acc;
        rdy = 1'b1;
        step();
        check("d_accepts", 32'(acc - a0), 32'h1);
        check("d_after_valid", 32'(f.instr_valid), 32'h0);
        check("d_after_addr", f.fetch_addr, 32'h4);

        // redirect while fetching the upper half of a span
        mem[0] = {16'h0093, 16'h4501};
        mem[64] = 32'h00A0_0093;
        do_reset();
        expect_instr("e0", 32'h0000_0513, 32'h0, 1'b1, 1'b0);
        mem_ok = 1'b0;
        step();
        check("e_hi_req", 32'(f.fetch_req), 32'h1);
        check("e_hi_addr", f.fetch_addr, 32'h4);
        f0 = fcount;
        redir = 1'b1;
        redir_pc = 32'h100;
        mem_ok = 1'b1;
        #1;
        check("e_redir_valid", 32'(f.instr_valid), 32'h0);
        step();
        redir = 1'b0;
        #1;
        check("e_new_addr", f.fetch_addr, 32'h100);
        check("e_dropped", 32'(fcount - f0), 32'h0);
        expect_instr("e1", 32'h00A0_0093, 32'h100, 1'b0, 1'b0);

        // PC wrap past the top of the address space
        mem[127] = {16'h4505, 16'h0013};
        redir = 1'b1;
        redir_pc = 32'hFFFF_FFFE;
        step();
        redir = 1'b0;
        #1;
        expect_instr("f0", 32'h0010_0513, 32'hFFFF_FFFE, 1'b1, 1'b0);
        check("f_wrap_addr", f.fetch_addr, 32'h0);

        // RVC disabled instance, held stalled on its first parcel
        check("g_valid", 32'(f2.instr_valid), 32'h1);
        check("g_ill", 32'(f2.instr_illegal), 32'h1);
        check("g_instr", f2.instr, 32'h0);
        check("g_comp", 32'(f2.instr_compressed), 32'h1);
        check("g_den", 32'(f2.dec_enable), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
